// File: rtl/vga_bounce_box.sv
// vga_bounce_box
//   Draws a solid box over a flat background and moves it once per frame,
//   reflecting off the edges of the active area.
//
// Ports
//   clk        : pixel clock
//   rst        : asynchronous, active-high reset
//   pix_x      : active-relative column (valid when active=1)
//   pix_y      : active-relative line   (valid when active=1)
//   active     : upstream timing is in the active video region
//   frame_tick : one-cycle pulse at start of vertical blanking
//   enable     : motion enable, sampled on frame_tick
//   step       : pixels moved per frame per axis, sampled on frame_tick
//   pixel      : registered RGB444 {R,G,B}, one clock after the coordinates
//   box_x      : current box left edge
//   box_y      : current box top edge
//   bounce     : one-cycle pulse when either axis reached an edge this frame
module vga_bounce_box #(
  parameter int unsigned H_ACT     = 640,
  parameter int unsigned V_ACT     = 480,
  parameter int unsigned BOX_W     = 32,
  parameter int unsigned BOX_H     = 32,
  parameter int unsigned INIT_X    = 0,
  parameter int unsigned INIT_Y    = 0,
  parameter logic [11:0] BOX_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR  = 12'h00F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        active,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [3:0]  step,
  output logic [11:0] pixel,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic        bounce
);

  // Largest legal left/top edge; the box never leaves the active area.
  localparam logic [10:0] X_MAX   = 11'(H_ACT - BOX_W);
  localparam logic [10:0] Y_MAX   = 11'(V_ACT - BOX_H);
  localparam logic [10:0] BOX_W_L = 11'(BOX_W);
  localparam logic [10:0] BOX_H_L = 11'(BOX_H);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_UPD_X = 2'd1,
    ST_UPD_Y = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic       dir;
    logic [9:0] pos;
  } axis_t;

  // One axis of motion: dir=1 moves toward lim, dir=0 toward zero. Reaching
  // or passing an edge clamps to it, reverses direction and reports a hit.
  function automatic axis_t axis_step(input logic [9:0]  pos,
                                      input logic        dir,
                                      input logic [3:0]  stp,
                                      input logic [10:0] lim);
    axis_t      res;
    logic [10:0] sum;
    sum = {1'b0, pos} + {7'd0, stp};
    if (dir) begin
      if (sum >= lim) begin
        res = '{hit: 1'b1, dir: 1'b0, pos: lim[9:0]};
      end else begin
        res = '{hit: 1'b0, dir: 1'b1, pos: sum[9:0]};
      end
    end else begin
      if ({1'b0, pos} <= {7'd0, stp}) begin
        res = '{hit: 1'b1, dir: 1'b1, pos: 10'd0};
      end else begin
        res = '{hit: 1'b0, dir: 1'b0, pos: pos - {6'd0, stp}};
      end
    end
    return res;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        start_s;
  logic [9:0]  box_x_r;
  logic [9:0]  box_y_r;
  logic        dx_r;
  logic        dy_r;
  logic [3:0]  step_q_r;
  logic        hit_x_r;
  logic        hit_y_r;
  logic        bounce_r;
  logic [11:0] pixel_r;
  axis_t       x_res_s;
  axis_t       y_res_s;
  logic        inside_s;

  // Update sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; ticks outside WAIT are dropped, not queued.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (frame_tick && enable && (step != 4'd0)) begin
          state_nxt_s = ST_UPD_X;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_UPD_X: state_nxt_s = ST_UPD_Y;
      ST_UPD_Y: state_nxt_s = ST_WAIT;
      default:  state_nxt_s = ST_WAIT;
    endcase
  end

  // Candidate next positions for both axes from the latched step.
  always_comb begin
    x_res_s = axis_step(box_x_r, dx_r, step_q_r, X_MAX);
    y_res_s = axis_step(box_y_r, dy_r, step_q_r, Y_MAX);
  end

  // Position, direction, hit flags and bounce pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x_r  <= 10'(INIT_X);
      box_y_r  <= 10'(INIT_Y);
      dx_r     <= 1'b1;
      dy_r     <= 1'b1;
      step_q_r <= 4'd0;
      hit_x_r  <= 1'b0;
      hit_y_r  <= 1'b0;
      bounce_r <= 1'b0;
    end else begin
      bounce_r <= 1'b0;
      case (state_r)
        ST_WAIT: begin
          if (start_s) begin
            step_q_r <= step;
            hit_x_r  <= 1'b0;
            hit_y_r  <= 1'b0;
          end
        end
        ST_UPD_X: begin
          box_x_r <= x_res_s.pos;
          dx_r    <= x_res_s.dir;
          hit_x_r <= x_res_s.hit;
        end
        ST_UPD_Y: begin
          box_y_r  <= y_res_s.pos;
          dy_r     <= y_res_s.dir;
          hit_y_r  <= y_res_s.hit;
          // Y hit is folded in directly since its flag lands this same edge.
          bounce_r <= hit_x_r | y_res_s.hit;
        end
        default: begin
          bounce_r <= 1'b0;
        end
      endcase
    end
  end

  // Containment test against the current box edges, widened to avoid wrap.
  always_comb begin
    inside_s = ({1'b0, pix_x} >= {1'b0, box_x_r}) &&
               ({1'b0, pix_x} <  ({1'b0, box_x_r} + BOX_W_L)) &&
               ({1'b0, pix_y} >= {1'b0, box_y_r}) &&
               ({1'b0, pix_y} <  ({1'b0, box_y_r} + BOX_H_L));
  end

  // Registered pixel colour, black outside the active region.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_r <= 12'h000;
    end else if (!active) begin
      pixel_r <= 12'h000;
    end else if (inside_s) begin
      pixel_r <= BOX_COLOR;
    end else begin
      pixel_r <= BG_COLOR;
    end
  end

  assign pixel  = pixel_r;
  assign box_x  = box_x_r;
  assign box_y  = box_y_r;
  assign bounce = bounce_r;

endmodule
